// File: rtl/pic_pc_stack_unit_pkg.sv
// Shared definitions for the PC / return-stack unit: command codes,
// default vectors and the strobe priority selector.
package pic_pc_stack_unit_pkg;

  typedef enum logic [2:0] {
    CMD_NONE = 3'd0,
    CMD_INCR = 3'd1,
    CMD_J    = 3'd2,
    CMD_PUSH = 3'd3,
    CMD_POP  = 3'd4,
    CMD_INT  = 3'd5,
    CMD_PCL  = 3'd6
  } cmd_e;

  localparam int DEFAULT_RESET_VECTOR = 0;
  localparam int DEFAULT_INT_VECTOR   = 4;

  // Only the highest-priority strobe acts; the others are ignored this cycle.
  function automatic cmd_e select_cmd(
    input logic int_en,
    input logic pop_en,
    input logic push_en,
    input logic j_en,
    input logic pcl_en,
    input logic incr_en
  );
    if (int_en)       return CMD_INT;
    else if (pop_en)  return CMD_POP;
    else if (push_en) return CMD_PUSH;
    else if (j_en)    return CMD_J;
    else if (pcl_en)  return CMD_PCL;
    else if (incr_en) return CMD_INCR;
    else              return CMD_NONE;
  endfunction

endpackage

// File: rtl/pic_pc_stack_unit_return_stack.sv
// Circular return-address stack. On a full push it either overwrites the
// oldest entry (WRAP=1) or drops the push (WRAP=0); an empty pop either
// walks back onto stale data (WRAP=1) or leaves the pointer alone (WRAP=0).
module return_stack #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 8,
  parameter int WRAP  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           data_in,
  output logic [WIDTH-1:0]           data_out,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow_evt,
  output logic                       underflow_evt
);

  localparam int SP_W  = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] entries [DEPTH];
  logic [SP_W-1:0]  sp;
  logic [SP_W-1:0]  sp_inc;
  logic [SP_W-1:0]  sp_dec;
  logic             full;
  logic             empty;

  // Pointer arithmetic is modulo DEPTH, which need not be a power of two.
  always_comb begin
    sp_inc        = (sp == SP_W'(DEPTH-1)) ? '0 : sp + SP_W'(1);
    sp_dec        = (sp == '0) ? SP_W'(DEPTH-1) : sp - SP_W'(1);
    full          = (count == CNT_W'(DEPTH));
    empty         = (count == '0);
    data_out      = entries[sp_dec];
    overflow_evt  = push && full;
    underflow_evt = pop && empty;
  end

  // Pointer, occupancy and storage update; the top never pushes and pops together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else if (push) begin
      if (!full || WRAP != 0) begin
        entries[sp] <= data_in;
        sp          <= sp_inc;
      end
      if (!full) count <= count + CNT_W'(1);
    end else if (pop) begin
      if (!empty || WRAP != 0) sp <= sp_dec;
      if (!empty) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pic_pc_stack_unit.sv
// Program counter, PCLATH latch, command priority and sticky stack error
// flags around a return_stack instance.
module pic_pc_stack_unit
  import pic_pc_stack_unit_pkg::*;
#(
  parameter int PC_WIDTH     = 13,
  parameter int STACK_DEPTH  = 8,
  parameter int RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int INT_VECTOR   = DEFAULT_INT_VECTOR,
  parameter int STACK_WRAP   = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             pc_incr_en,
  input  logic                             pc_j_en,
  input  logic                             pc_j_and_push_en,
  input  logic                             pc_j_by_pop_en,
  input  logic                             int_entry_en,
  input  logic [10:0]                      pc_j_addr,
  input  logic                             pcl_wr_en,
  input  logic [7:0]                       pcl_in,
  input  logic                             pclath_wr_en,
  input  logic [PC_WIDTH-9:0]              pclath_in,
  input  logic                             stack_err_clr,
  output logic [PC_WIDTH-1:0]              pc_out,
  output logic [7:0]                       pcl_out,
  output logic [PC_WIDTH-9:0]              pclath_out,
  output logic [$clog2(STACK_DEPTH+1)-1:0] stack_count,
  output logic                             stack_overflow,
  output logic                             stack_underflow
);

  cmd_e                cmd;
  logic [PC_WIDTH-1:0] pc_next;
  logic [PC_WIDTH-1:0] jump_addr;
  logic [PC_WIDTH-1:0] stk_top;
  logic                stk_push;
  logic                stk_pop;
  logic                overflow_evt;
  logic                underflow_evt;

  return_stack #(
    .WIDTH (PC_WIDTH),
    .DEPTH (STACK_DEPTH),
    .WRAP  (STACK_WRAP)
  ) u_stack (
    .clk           (clk),
    .rst           (rst),
    .push          (stk_push),
    .pop           (stk_pop),
    .data_in       (pc_out),
    .data_out      (stk_top),
    .count         (stack_count),
    .overflow_evt  (overflow_evt),
    .underflow_evt (underflow_evt)
  );

  assign pcl_out = pc_out[7:0];

  // Pick the winning command and compute the next PC; jumps use the current PCLATH.
  always_comb begin
    cmd       = select_cmd(int_entry_en, pc_j_by_pop_en, pc_j_and_push_en,
                           pc_j_en, pcl_wr_en, pc_incr_en);
    jump_addr = {pclath_out[PC_WIDTH-9:3], pc_j_addr};
    stk_push  = (cmd == CMD_PUSH) || (cmd == CMD_INT);
    stk_pop   = (cmd == CMD_POP);
    pc_next   = pc_out;
    case (cmd)
      CMD_INT:  pc_next = PC_WIDTH'(INT_VECTOR);
      CMD_POP:  pc_next = (underflow_evt && STACK_WRAP == 0) ? PC_WIDTH'(RESET_VECTOR) : stk_top;
      CMD_PUSH: pc_next = jump_addr;
      CMD_J:    pc_next = jump_addr;
      CMD_PCL:  pc_next = {pclath_out, pcl_in};
      CMD_INCR: pc_next = pc_out + PC_WIDTH'(1);
      default:  pc_next = pc_out;
    endcase
  end

  // PC, PCLATH and sticky flags; a new error event beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_out          <= PC_WIDTH'(RESET_VECTOR);
      pclath_out      <= '0;
      stack_overflow  <= 1'b0;
      stack_underflow <= 1'b0;
    end else begin
      pc_out <= pc_next;
      if (pclath_wr_en) pclath_out <= pclath_in;
      if (overflow_evt)       stack_overflow <= 1'b1;
      else if (stack_err_clr) stack_overflow <= 1'b0;
      if (underflow_evt)      stack_underflow <= 1'b1;
      else if (stack_err_clr) stack_underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pic_pc_stack_unit.sv
// Bench for pic_pc_stack_unit: a wrapping and a saturating instance share
// stimulus and are compared against a behavioural model of each.
module tb_pic_pc_stack_unit;

  localparam int PCW   = 13;
  localparam int DEPTH = 8;
  localparam int RV    = 0;
  localparam int IV    = 4;
  localparam int MASK  = (1 << PCW) - 1;

  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_INCR = 6'b000001;
  localparam logic [5:0] C_PCL  = 6'b000010;
  localparam logic [5:0] C_J    = 6'b000100;
  localparam logic [5:0] C_CALL = 6'b001000;
  localparam logic [5:0] C_RET  = 6'b010000;
  localparam logic [5:0] C_INT  = 6'b100000;

  logic clk = 1'b0;
  logic rst;
  logic pc_incr_en, pc_j_en, pc_j_and_push_en, pc_j_by_pop_en, int_entry_en;
  logic [10:0] pc_j_addr;
  logic pcl_wr_en;
  logic [7:0] pcl_in;
  logic pclath_wr_en;
  logic [PCW-9:0] pclath_in;
  logic stack_err_clr;

  logic [PCW-1:0] pc_w, pc_s;
  logic [7:0] pcl_w, pcl_s;
  logic [PCW-9:0] pclath_w, pclath_s;
  logic [3:0] cnt_w, cnt_s;
  logic ovf_w, ovf_s, unf_w, unf_s;

  int checks = 0;
  int errors = 0;

  // Model state, index 0 = wrapping instance, 1 = saturating instance.
  int m_pc[2], m_pclath[2], m_sp[2], m_cnt[2];
  bit m_ovf[2], m_unf[2];
  int m_stk[2][DEPTH];

  always #5 clk = ~clk;

  pic_pc_stack_unit #(.PC_WIDTH(PCW), .STACK_DEPTH(DEPTH), .RESET_VECTOR(RV),
                      .INT_VECTOR(IV), .STACK_WRAP(1)) dut_wrap (
    .clk(clk), .rst(rst), .pc_incr_en(pc_incr_en), .pc_j_en(pc_j_en),
    .pc_j_and_push_en(pc_j_and_push_en), .pc_j_by_pop_en(pc_j_by_pop_en),
    .int_entry_en(int_entry_en), .pc_j_addr(pc_j_addr), .pcl_wr_en(pcl_wr_en),
    .pcl_in(pcl_in), .pclath_wr_en(pclath_wr_en), .pclath_in(pclath_in),
    .stack_err_clr(stack_err_clr), .pc_out(pc_w), .pcl_out(pcl_w),
    .pclath_out(pclath_w), .stack_count(cnt_w), .stack_overflow(ovf_w),
    .stack_underflow(unf_w)
  );

  pic_pc_stack_unit #(.PC_WIDTH(PCW), .STACK_DEPTH(DEPTH), .RESET_VECTOR(RV),
                      .INT_VECTOR(IV), .STACK_WRAP(0)) dut_sat (
    .clk(clk), .rst(rst), .pc_incr_en(pc_incr_en), .pc_j_en(pc_j_en),
    .pc_j_and_push_en(pc_j_and_push_en), .pc_j_by_pop_en(pc_j_by_pop_en),
    .int_entry_en(int_entry_en), .pc_j_addr(pc_j_addr), .pcl_wr_en(pcl_wr_en),
    .pcl_in(pcl_in), .pclath_wr_en(pclath_wr_en), .pclath_in(pclath_in),
    .stack_err_clr(stack_err_clr), .pc_out(pc_s), .pcl_out(pcl_s),
    .pclath_out(pclath_s), .stack_count(cnt_s), .stack_overflow(ovf_s),
    .stack_underflow(unf_s)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_pc[m] = RV; m_pclath[m] = 0; m_sp[m] = 0; m_cnt[m] = 0;
      m_ovf[m] = 0; m_unf[m] = 0;
      for (int i = 0; i < DEPTH; i++) m_stk[m][i] = 0;
    end
  endtask

  task automatic model_push(input int m, input int val, output bit evt);
    evt = (m_cnt[m] == DEPTH);
    if (!evt) begin
      m_stk[m][m_sp[m]] = val; m_sp[m] = (m_sp[m] + 1) % DEPTH; m_cnt[m]++;
    end else if (m == 0) begin
      m_stk[m][m_sp[m]] = val; m_sp[m] = (m_sp[m] + 1) % DEPTH;
    end
  endtask

  task automatic model_pop(input int m, output int val, output bit evt);
    evt = (m_cnt[m] == 0);
    if (!evt) begin
      m_sp[m] = (m_sp[m] + DEPTH - 1) % DEPTH; val = m_stk[m][m_sp[m]]; m_cnt[m]--;
    end else if (m == 0) begin
      m_sp[m] = (m_sp[m] + DEPTH - 1) % DEPTH; val = m_stk[m][m_sp[m]];
    end else begin
      val = RV;
    end
  endtask

  // Advance both models by one clock using the inputs currently driven.
  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      int nxt;
      int popped;
      bit oe;
      bit ue;
      int jmp;
      nxt = m_pc[m]; oe = 0; ue = 0; popped = 0;
      jmp = ((m_pclath[m] >> 3) << 11) | int'(pc_j_addr);
      if (int_entry_en) begin
        model_push(m, m_pc[m], oe); nxt = IV;
      end else if (pc_j_by_pop_en) begin
        model_pop(m, popped, ue); nxt = popped;
      end else if (pc_j_and_push_en) begin
        model_push(m, m_pc[m], oe); nxt = jmp;
      end else if (pc_j_en) begin
        nxt = jmp;
      end else if (pcl_wr_en) begin
        nxt = (m_pclath[m] << 8) | int'(pcl_in);
      end else if (pc_incr_en) begin
        nxt = m_pc[m] + 1;
      end
      m_pc[m] = nxt & MASK;
      if (pclath_wr_en) m_pclath[m] = int'(pclath_in);
      if (oe) m_ovf[m] = 1; else if (stack_err_clr) m_ovf[m] = 0;
      if (ue) m_unf[m] = 1; else if (stack_err_clr) m_unf[m] = 0;
    end
  endtask

  task automatic check_all();
    checkOutput("wrap.pc", 32'(pc_w), m_pc[0]);
    checkOutput("wrap.pcl", 32'(pcl_w), m_pc[0] & 8'hFF);
    checkOutput("wrap.pclath", 32'(pclath_w), m_pclath[0]);
    checkOutput("wrap.count", 32'(cnt_w), m_cnt[0]);
    checkOutput("wrap.ovf", 32'(ovf_w), 32'(m_ovf[0]));
    checkOutput("wrap.unf", 32'(unf_w), 32'(m_unf[0]));
    checkOutput("sat.pc", 32'(pc_s), m_pc[1]);
    checkOutput("sat.pcl", 32'(pcl_s), m_pc[1] & 8'hFF);
    checkOutput("sat.pclath", 32'(pclath_s), m_pclath[1]);
    checkOutput("sat.count", 32'(cnt_s), m_cnt[1]);
    checkOutput("sat.ovf", 32'(ovf_s), 32'(m_ovf[1]));
    checkOutput("sat.unf", 32'(unf_s), 32'(m_unf[1]));
  endtask

  // Drive one cycle of inputs, clock it, update the model and compare.
  task automatic applyStimulus(input logic [5:0] cmds, input logic [10:0] jaddr, input logic [7:0] pcl,
                               input logic lath_wr, input logic [PCW-9:0] lath, input logic clr);
    pc_incr_en = cmds[0]; pcl_wr_en = cmds[1]; pc_j_en = cmds[2];
    pc_j_and_push_en = cmds[3]; pc_j_by_pop_en = cmds[4]; int_entry_en = cmds[5];
    pc_j_addr = jaddr; pcl_in = pcl; pclath_wr_en = lath_wr; pclath_in = lath;
    stack_err_clr = clr;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  // Pulse the asynchronous reset between clock edges and check it acts at once.
  task automatic pulse_reset();
    #2 rst = 1'b0;
    #1;
    model_reset();
    checkOutput("async_rst.pc", 32'(pc_w), RV);
    checkOutput("async_rst.count", 32'(cnt_w), 0);
    check_all();
    #2 rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus_idle();
    #3;
    model_reset();
    check_all();
    #10 rst = 1'b1;

    // Increment from reset, then wrap at the top of the address space.
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(C_INCR, 11'h0, 8'h0, 1'b0, '0, 1'b0);
      checkOutput("incr.seq", 32'(pc_w), i);
    end
    applyStimulus(C_NONE, 11'h0, 8'h0, 1'b1, 5'h1F, 1'b0);
    applyStimulus(C_PCL, 11'h0, 8'hFF, 1'b0, '0, 1'b0);
    checkOutput("preload.1fff", 32'(pc_w), 32'h1FFF);
    applyStimulus(C_INCR, 11'h0, 8'h0, 1'b0, '0, 1'b0);
    checkOutput("incr.wrap", 32'(pc_w), 32'h0);

    // GOTO composed with PCLATH, and a same-cycle PCLATH write using the old value.
    applyStimulus(C_NONE, 11'h0, 8'h0, 1'b1, 5'h18, 1'b0);
    applyStimulus(C_J, 11'h123, 8'h0, 1'b0, '0, 1'b0);
    checkOutput("goto.1923", 32'(pc_w), 32'h1923);
    applyStimulus(C_J, 11'h055, 8'h0, 1'b1, 5'h00, 1'b0);
    checkOutput("goto.old_pclath", 32'(pc_w), 32'h1855);

    // Nested CALL / RETURN.
    applyStimulus(C_PCL, 11'h0, 8'h50, 1'b0, '0, 1'b0);
    applyStimulus(C_CALL, 11'h200, 8'h0, 1'b0, '0, 1'b0);
    checkOutput("call1.pc", 32'(pc_w), 32'h200);
    checkOutput("call1.count", 32'(cnt_w), 1);
    applyStimulus(C_CALL, 11'h300, 8'h0, 1'b0, '0, 1'b0);
    checkOutput("call2.pc", 32'(pc_w), 32'h300);
    applyStimulus(C_RET, 11'h0, 8'h0, 1'b0, '0, 1'b0);
    checkOutput("ret1.pc", 32'(pc_w), 32'h200);
    checkOutput("ret1.count", 32'(cnt_w), 1);
    applyStimulus(C_RET, 11'h0, 8'h0, 1'b0, '0, 1'b0);
    checkOutput("ret2.pc", 32'(pc_w), 32'h050);
    checkOutput("ret2.count", 32'(cnt_w), 0);

    // Nine pushes into eight slots, then eight pops.
    pulse_reset();
    for (int k = 1; k <= 9; k++)
      applyStimulus(C_CALL, 11'(k * 16), 8'h0, 1'b0, '0, 1'b0);
    checkOutput("full.ovf", 32'(ovf_w), 1);
    checkOutput("full.count", 32'(cnt_w), DEPTH);
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(C_RET, 11'h0, 8'h0, 1'b0, '0, 1'b0);
      if (k == 1) checkOutput("pop1.ninth", 32'(pc_w), 32'h080);
      if (k == 8) checkOutput("pop8.second", 32'(pc_w), 32'h010);
    end

    // Empty pop on the saturating stack, then clear and clear-vs-set.
    pulse_reset();
    applyStimulus(C_INCR, 11'h0, 8'h0, 1'b0, '0, 1'b0);
    applyStimulus(C_INCR, 11'h0, 8'h0, 1'b0, '0, 1'b0);
    applyStimulus(C_RET, 11'h0, 8'h0, 1'b0, '0, 1'b0);
    checkOutput("sat.empty_pop.pc", 32'(pc_s), RV);
    checkOutput("sat.empty_pop.unf", 32'(unf_s), 1);
    applyStimulus(C_NONE, 11'h0, 8'h0, 1'b0, '0, 1'b1);
    checkOutput("sat.clr.unf", 32'(unf_s), 0);
    applyStimulus(C_RET, 11'h0, 8'h0, 1'b0, '0, 1'b1);
    checkOutput("sat.set_beats_clr", 32'(unf_s), 1);

    // Interrupt beats GOTO and pushes the interrupted PC.
    applyStimulus(C_NONE, 11'h0, 8'h0, 1'b1, 5'h00, 1'b1);
    applyStimulus(C_PCL, 11'h0, 8'hA7, 1'b0, '0, 1'b0);
    applyStimulus(C_INT | C_J, 11'h7FF, 8'h0, 1'b0, '0, 1'b0);
    checkOutput("int.pc", 32'(pc_w), IV);
    applyStimulus(C_RET, 11'h0, 8'h0, 1'b0, '0, 1'b0);
    checkOutput("int.tos", 32'(pc_w), 32'h0A7);

    // Randomised mix of strobes, PCLATH writes and flag clears.
    for (int n = 0; n < 600; n++) begin
      logic [5:0] cmds;
      for (int b = 0; b < 6; b++) cmds[b] = ($urandom_range(0, 3) == 0);
      applyStimulus(cmds, 11'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0),
                    5'($urandom), ($urandom_range(0, 7) == 0));
      if (n == 300) pulse_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic applyStimulus_idle();
    pc_incr_en = 0; pc_j_en = 0; pc_j_and_push_en = 0; pc_j_by_pop_en = 0;
    int_entry_en = 0; pc_j_addr = '0; pcl_wr_en = 0; pcl_in = '0;
    pclath_wr_en = 0; pclath_in = '0; stack_err_clr = 0;
  endtask

endmodule
